count_pwm_gen: RTL and testbench

- Downstream consumer of the free-running up counter's count value; turns it into a registered PWM output.
- Holds a duty setting with valid/ready programming and a shadow register. New duty values take effect only at the counter wrap, so periods are always glitch-free.
- Also emits a period-start pulse for later stages.

---
 rtl/count_pwm_pkg.sv | 21 ++
 rtl/count_wrap_detect.sv | 24 ++
 rtl/count_pwm_gen.sv | 97 +++++++++
 tb/tb_count_pwm_gen.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_pwm_pkg.sv
// Shared types and helpers for the count-driven PWM generator.
package count_pwm_pkg;

   typedef enum logic {
      SYNC,
      RUN
   } state_e;

   localparam int unsigned CNT_W_DEF = 4;

   // Saturate a requested high-time at one full period (2^w counts).
   function automatic logic [31:0] clamp_duty(
      input logic [31:0] duty,
      input int unsigned w
   );
      logic [31:0] lim;
      lim = 32'd1 << w;
      return (duty > lim) ? lim : duty;
   endfunction

endpackage

// File: rtl/count_wrap_detect.sv
// Flags the first cycle of each counter period (entry to zero).
module count_wrap_detect #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] count_i,
   output logic             boundary_o
);

   logic [CNT_W-1:0] prev_q;

   // All-ones at reset so the first zero seen counts as a wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= '1;
      end else begin
         prev_q <= count_i;
      end
   end

   assign boundary_o = (count_i == '0) && (prev_q != '0);

endmodule

// File: rtl/count_pwm_gen.sv
// Registered PWM from an upstream count, with shadowed duty updates
// that only take effect at the counter wrap.
module count_pwm_gen
   import count_pwm_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] count_in,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W:0]   cfg_duty,
   output logic             cfg_applied,
   output logic             period_start,
   output logic             pwm_out
);

   localparam int unsigned DW = CNT_W + 1;

   state_e        state_q;
   logic [DW-1:0] active_q;
   logic [DW-1:0] pend_q;
   logic          pending_q;
   logic          pwm_q;
   logic          ps_q;
   logic          applied_q;

   logic          boundary;
   logic          accept;
   logic          apply;
   logic [DW-1:0] duty_d;
   logic [DW-1:0] duty_used;
   logic [DW-1:0] count_ext;

   count_wrap_detect #(
      .CNT_W (CNT_W)
   ) u_wrap (
      .clk        (clk),
      .rst_n      (rst_n),
      .count_i    (count_in),
      .boundary_o (boundary)
   );

   assign cfg_ready = !pending_q;
   assign accept    = cfg_valid && !pending_q;
   assign apply     = boundary && pending_q;
   assign duty_d    = DW'(clamp_duty(32'(cfg_duty), CNT_W));
   assign count_ext = {1'b0, count_in};

   // A duty applied at the wrap already governs the wrap cycle itself.
   assign duty_used = apply ? pend_q : active_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= SYNC;
         active_q  <= '0;
         pend_q    <= '0;
         pending_q <= 1'b0;
         pwm_q     <= 1'b0;
         ps_q      <= 1'b0;
         applied_q <= 1'b0;
      end else begin
         applied_q <= apply;
         if (apply) begin
            active_q  <= pend_q;
            pending_q <= 1'b0;
         end else if (accept) begin
            pend_q    <= duty_d;
            pending_q <= 1'b1;
         end
         unique case (state_q)
            SYNC: begin
               pwm_q <= boundary && (count_ext < duty_used);
               ps_q  <= boundary;
               if (boundary) begin
                  state_q <= RUN;
               end
            end
            RUN: begin
               pwm_q <= count_ext < duty_used;
               ps_q  <= boundary;
            end
            default: begin
               state_q <= SYNC;
               pwm_q   <= 1'b0;
               ps_q    <= 1'b0;
            end
         endcase
      end
   end

   assign pwm_out      = pwm_q;
   assign period_start = ps_q;
   assign cfg_applied  = applied_q;

endmodule

// File: tb/tb_count_pwm_gen.sv
// Self-checking bench for count_pwm_gen against a period-level model.
module tb_count_pwm_gen;

   localparam int CNT_W  = 4;
   localparam int PERIOD = 16;

   logic             clk = 1'b1;
   logic             rst_n;
   logic [CNT_W-1:0] count_in;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [CNT_W:0]   cfg_duty;
   logic             cfg_applied;
   logic             period_start;
   logic             pwm_out;
   logic [3:0]       obs;

   always #5 clk = ~clk;

   count_pwm_gen #(
      .CNT_W (CNT_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .count_in     (count_in),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_duty     (cfg_duty),
      .cfg_applied  (cfg_applied),
      .period_start (period_start),
      .pwm_out      (pwm_out)
   );

   assign obs = {cfg_ready, cfg_applied, period_start, pwm_out};

   int n_vec = 0;
   int n_err = 0;

   int m_prev;
   int m_active;
   int m_pend[$];
   bit m_sync, m_pwm, m_ps, m_app, m_acc;

   int cur_hi = 0;
   int last_hi = 0;
   int n_app = 0;
   int n_ps = 0;

   function automatic void model_reset();
      m_prev   = PERIOD - 1;
      m_active = 0;
      m_pend.delete();
      m_sync   = 0;
      m_pwm    = 0;
      m_ps     = 0;
      m_app    = 0;
      m_acc    = 0;
   endfunction

   function automatic void model_step();
      bit bnd;
      if (!rst_n) begin
         model_reset();
         return;
      end
      bnd    = (int'(count_in) == 0) && (m_prev != 0);
      m_prev = int'(count_in);
      m_acc  = cfg_valid && (m_pend.size() == 0);
      m_app  = 0;
      if (bnd && m_pend.size() != 0) begin
         m_active = m_pend.pop_front();
         m_app    = 1;
      end
      if (m_acc)
         m_pend.push_back(int'(cfg_duty) > PERIOD ? PERIOD : int'(cfg_duty));
      if (bnd) m_sync = 1;
      m_pwm = m_sync && (int'(count_in) < m_active);
      m_ps  = m_sync && bnd;
   endfunction

   function automatic logic [3:0] exp_v();
      return {m_pend.size() == 0, m_app, m_ps, m_pwm};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (period_start === 1'b1) begin
         last_hi = cur_hi;
         cur_hi  = 0;
         n_ps++;
      end
      if (pwm_out === 1'b1) cur_hi++;
      if (cfg_applied === 1'b1) n_app++;
      if (m_acc) cfg_valid = 1'b0;
      count_in = count_in + 1'b1;
   endtask

   task automatic test_reset();
      model_reset();
      rst_n     = 1'b0;
      cfg_valid = 1'b0;
      cfg_duty  = '0;
      count_in  = 4'd1;
      #5;
      n_vec++;
      if (obs !== 4'b1000) begin
         n_err++;
         $display("FAIL reset_early got %b exp 1000", obs);
      end
      #7;
      n_vec++;
      if (obs !== 4'b1000) begin
         n_err++;
         $display("FAIL reset_late got %b exp 1000", obs);
      end
      #3;
      rst_n = 1'b1;
      #1;
      n_vec++;
      if ($isunknown(obs) || obs !== 4'b1000) begin
         n_err++;
         $display("FAIL reset_release got %b exp 1000", obs);
      end
   endtask

   task automatic test_first_duty();
      bit found = 0;
      cfg_duty  = 5'd4;
      cfg_valid = 1'b1;
      tick();
      n_vec++;
      if (obs !== exp_v() || cfg_ready !== 1'b0) begin
         n_err++;
         $display("FAIL first_accept got %b exp %b", obs, exp_v());
      end
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         n_vec++;
         if (obs !== exp_v()) begin
            n_err++;
            $display("FAIL first_wait got %b exp %b", obs, exp_v());
         end
         if (cfg_applied === 1'b1) found = 1;
      end
      n_vec++;
      if (!found || period_start !== 1'b1 || pwm_out !== 1'b1) begin
         n_err++;
         $display("FAIL first_apply got app=%0b ps=%b pwm=%b exp 1 1 1",
                  found, period_start, pwm_out);
      end
      n_ps = 0;
      repeat (32) begin
         tick();
         n_vec++;
         if (obs !== exp_v()) begin
            n_err++;
            $display("FAIL first_run got %b exp %b", obs, exp_v());
         end
      end
      n_vec++;
      if (last_hi !== 4 || n_ps !== 2) begin
         n_err++;
         $display("FAIL first_shape got hi=%0d ps=%0d exp hi=4 ps=2",
                  last_hi, n_ps);
      end
   endtask

   task automatic test_change();
      bit found = 0;
      for (int i = 0; i < 20 && count_in != 4'd7; i++) begin
         tick();
         n_vec++;
         if (obs !== exp_v()) begin
            n_err++;
            $display("FAIL change_seek got %b exp %b", obs, exp_v());
         end
      end
      cfg_duty  = 5'd12;
      cfg_valid = 1'b1;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         n_vec++;
         if (obs !== exp_v()) begin
            n_err++;
            $display("FAIL change_wait got %b exp %b", obs, exp_v());
         end
         if (cfg_applied === 1'b1) found = 1;
      end
      n_vec++;
      if (!found || last_hi !== 4) begin
         n_err++;
         $display("FAIL change_old got app=%0b hi=%0d exp app=1 hi=4",
                  found, last_hi);
      end
      repeat (16) begin
         tick();
         n_vec++;
         if (obs !== exp_v()) begin
            n_err++;
            $display("FAIL change_run got %b exp %b", obs, exp_v());
         end
      end
      n_vec++;
      if (last_hi !== 12 || cfg_ready !== 1'b1) begin
         n_err++;
         $display("FAIL change_new got hi=%0d rdy=%b exp hi=12 rdy=1",
                  last_hi, cfg_ready);
      end
   endtask

   task automatic test_extremes();
      int duties[3] = '{0, 16, 31};
      int highs[3]  = '{0, 16, 16};
      for (int k = 0; k < 3; k++) begin
         cfg_duty  = 5'(duties[k]);
         cfg_valid = 1'b1;
         n_ps      = 0;
         repeat (50) begin
            tick();
            n_vec++;
            if (obs !== exp_v()) begin
               n_err++;
               $display("FAIL extreme_run d=%0d got %b exp %b",
                        duties[k], obs, exp_v());
            end
         end
         n_vec++;
         if (last_hi !== highs[k] || n_ps < 3) begin
            n_err++;
            $display("FAIL extreme_shape d=%0d got hi=%0d ps=%0d exp hi=%0d",
                     duties[k], last_hi, n_ps, highs[k]);
         end
      end
   endtask

   task automatic test_boundary_write();
      for (int i = 0; i < 20 && count_in != 4'd0; i++) begin
         tick();
         n_vec++;
         if (obs !== exp_v()) begin
            n_err++;
            $display("FAIL bwrite_seek got %b exp %b", obs, exp_v());
         end
      end
      cfg_duty  = 5'd8;
      cfg_valid = 1'b1;
      tick();
      n_vec++;
      if (obs !== exp_v() || obs !== 4'b0011) begin
         n_err++;
         $display("FAIL bwrite_edge got %b exp 0011", obs);
      end
      repeat (16) begin
         tick();
         n_vec++;
         if (obs !== exp_v()) begin
            n_err++;
            $display("FAIL bwrite_run got %b exp %b", obs, exp_v());
         end
      end
      n_vec++;
      if (cfg_applied !== 1'b1 || last_hi !== 16) begin
         n_err++;
         $display("FAIL bwrite_late got app=%b hi=%0d exp app=1 hi=16",
                  cfg_applied, last_hi);
      end
      repeat (16) begin
         tick();
         n_vec++;
         if (obs !== exp_v()) begin
            n_err++;
            $display("FAIL bwrite_after got %b exp %b", obs, exp_v());
         end
      end
      n_vec++;
      if (last_hi !== 8) begin
         n_err++;
         $display("FAIL bwrite_new got hi=%0d exp 8", last_hi);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 20 && count_in != 4'd2; i++) begin
         tick();
         n_vec++;
         if (obs !== exp_v()) begin
            n_err++;
            $display("FAIL rmid_seek got %b exp %b", obs, exp_v());
         end
      end
      cfg_duty  = 5'd10;
      cfg_valid = 1'b1;
      for (int i = 0; i < 20 && count_in != 4'd9; i++) begin
         tick();
         n_vec++;
         if (obs !== exp_v()) begin
            n_err++;
            $display("FAIL rmid_pend got %b exp %b", obs, exp_v());
         end
      end
      rst_n = 1'b0;
      model_reset();
      #1;
      n_vec++;
      if (obs !== 4'b1000) begin
         n_err++;
         $display("FAIL rmid_async got %b exp 1000", obs);
      end
      repeat (2) tick();
      rst_n  = 1'b1;
      n_app  = 0;
      cur_hi = 0;
      repeat (40) begin
         tick();
         n_vec++;
         if (obs !== exp_v()) begin
            n_err++;
            $display("FAIL rmid_run got %b exp %b", obs, exp_v());
         end
      end
      n_vec++;
      if (n_app !== 0 || last_hi !== 0 || cur_hi !== 0) begin
         n_err++;
         $display("FAIL rmid_idle got app=%0d hi=%0d exp app=0 hi=0",
                  n_app, last_hi);
      end
   endtask

   task automatic test_random();
      int r;
      repeat (800) begin
         r = $urandom_range(0, 31);
         if (r == 0) count_in = 4'($urandom);
         else if (r == 1) count_in = count_in - 1'b1;
         else if (r == 2) count_in = 4'd0;
         if (!cfg_valid && $urandom_range(0, 3) == 0) begin
            cfg_valid = 1'b1;
            cfg_duty  = 5'($urandom);
         end
         if (r == 3 && $urandom_range(0, 3) == 0) begin
            rst_n = 1'b0;
            model_reset();
            #1;
            n_vec++;
            if (obs !== 4'b1000) begin
               n_err++;
               $display("FAIL rand_reset got %b exp 1000", obs);
            end
            tick();
            rst_n = 1'b1;
         end
         tick();
         n_vec++;
         if (obs !== exp_v()) begin
            n_err++;
            $display("FAIL rand got %b exp %b cnt=%0d", obs, exp_v(),
                     count_in);
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_duty();
      test_change();
      test_extremes();
      test_boundary_write();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
